// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_pkg
//  Purpose  : Shared DES constants: PC-1/PC-2 selection tables, key-shift
//             schedule, widths and key-schedule FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;
    localparam int ROUND_W  = 4;

    // Entries are 1-based DES bit numbers, DES bit 1 being the MSB.
    localparam int PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount applied before subkey K(i+1).
    localparam logic [1:0] SHIFTS [ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : des_pkg
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
//  Module   : des_pc2
//  Purpose  : Combinational DES Permuted Choice 2, 56-bit {C,D} -> 48-bit key.
//  Revision : 1.0  initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     cd,
    output logic [SUBKEY_W-1:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            subkey[SUBKEY_W-1-i] = cd[CD_W-PC2[i]];
        end
    end

endmodule : des_pc2
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : des_key_schedule
//  Purpose  : Sequential DES subkey generator streaming K1..K16 (or K16..K1)
//             over a valid/ready handshake. Reverse order requires the
//             DES_KEY_DECRYPT_EN build macro; otherwise Decrypt is ignored.
//  Revision : 1.0  initial release
// ============================================================================
module des_key_schedule
    import des_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [KEY_W-1:0]    Key,
    input  logic                Decrypt,
    input  logic                SubKeyReady,
    output logic [SUBKEY_W-1:0] SubKey,
    output logic                SubKeyValid,
    output logic [ROUND_W-1:0]  Round,
    output logic                Busy,
    output logic                Done
);

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int i = 0; i < CD_W; i++) begin
            cd[CD_W-1-i] = key[KEY_W-PC1[i]];
        end
        return cd;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x,
                                               input logic [1:0] amt);
        return (amt == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                             : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

`ifdef DES_KEY_DECRYPT_EN
    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x,
                                               input logic [1:0] amt);
        return (amt == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                             : {x[0], x[HALF_W-1:1]};
    endfunction
`endif

    state_t               r_state;
    logic [HALF_W-1:0]    r_c;
    logic [HALF_W-1:0]    r_d;
    logic [ROUND_W-1:0]   r_round;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;

    logic [CD_W-1:0]      w_cd0;
    logic [HALF_W-1:0]    w_c_load;
    logic [HALF_W-1:0]    w_d_load;
    logic [HALF_W-1:0]    w_c_next;
    logic [HALF_W-1:0]    w_d_next;
    logic [ROUND_W-1:0]   w_round_next;
    logic [1:0]           w_shift;
    logic                 w_fire;
    logic                 w_unused_parity;

    // Parity bits (DES bits 8,16,..,64) never reach PC-1.
    assign w_unused_parity = ^{Key[56], Key[48], Key[40], Key[32],
                               Key[24], Key[16], Key[8],  Key[0]};

    assign w_cd0        = pc1(Key);
    assign w_round_next = r_round + 4'd1;
    assign w_shift      = SHIFTS[w_round_next];
    assign w_fire       = r_valid & SubKeyReady;

`ifdef DES_KEY_DECRYPT_EN
    logic r_dir;

    // Decrypt starts from the unrotated C0/D0: total rotation is 28, so that is K16.
    assign w_c_load = Decrypt ? w_cd0[CD_W-1:HALF_W] : rotl(w_cd0[CD_W-1:HALF_W], 2'd1);
    assign w_d_load = Decrypt ? w_cd0[HALF_W-1:0]    : rotl(w_cd0[HALF_W-1:0], 2'd1);
    assign w_c_next = r_dir ? rotr(r_c, w_shift) : rotl(r_c, w_shift);
    assign w_d_next = r_dir ? rotr(r_d, w_shift) : rotl(r_d, w_shift);
`else
    logic w_unused_decrypt;

    assign w_unused_decrypt = Decrypt;
    assign w_c_load = rotl(w_cd0[CD_W-1:HALF_W], 2'd1);
    assign w_d_load = rotl(w_cd0[HALF_W-1:0], 2'd1);
    assign w_c_next = rotl(r_c, w_shift);
    assign w_d_next = rotl(r_d, w_shift);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef DES_KEY_DECRYPT_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_state <= ST_RUN;
                        r_c     <= w_c_load;
                        r_d     <= w_d_load;
                        r_round <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef DES_KEY_DECRYPT_EN
                        r_dir   <= Decrypt;
`endif
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
                        if (r_round == 4'd15) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_round <= w_round_next;
                            r_c     <= w_c_next;
                            r_d     <= w_d_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd     ({r_c, r_d}),
        .subkey (SubKey)
    );

    assign SubKeyValid = r_valid;
    assign Round       = r_round;
    assign Busy        = r_busy;
    assign Done        = r_done;

endmodule : des_key_schedule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_key_schedule
//  Purpose  : Directed self-checking bench for des_key_schedule.
//  Revision : 1.0  initial release
// ============================================================================
module tb_des_key_schedule;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [63:0] Key;
    logic        Decrypt;
    logic        SubKeyReady;
    logic [47:0] SubKey;
    logic        SubKeyValid;
    logic [3:0]  Round;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int passed = 0;

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_ONE = 64'hFFFFFFFFFFFFFFFF;
`ifdef DES_KEY_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    // Subkeys K1..K16 of KEY_A (classic worked example).
    logic [47:0] k_tab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_schedule dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Key         (Key),
        .Decrypt     (Decrypt),
        .SubKeyReady (SubKeyReady),
        .SubKey      (SubKey),
        .SubKeyValid (SubKeyValid),
        .Round       (Round),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    task automatic wait_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Key = '0; Decrypt = 1'b0; SubKeyReady = 1'b0;
        repeat (3) wait_cycle();
        Reset = 1'b0;
        wait_cycle();
        checks++;
        if (SubKeyValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Round !== 4'd0 || SubKey !== 48'h0) begin
            $display("FAIL reset: valid=%b busy=%b done=%b round=%0d subkey=%h, want 0 0 0 0 0",
                     SubKeyValid, Busy, Done, Round, SubKey);
        end else passed++;
    endtask

    task automatic test_encrypt(input logic [63:0] key, input string tag);
        Key = key; Decrypt = 1'b0; Start = 1'b1; SubKeyReady = 1'b1;
        wait_cycle();
        Start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (SubKeyValid !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0 ||
                Round !== i[3:0] || SubKey !== k_tab[i]) begin
                $display("FAIL %s_k%0d: valid=%b busy=%b done=%b round=%0d subkey=%h, want 1 1 0 %0d %h",
                         tag, i, SubKeyValid, Busy, Done, Round, SubKey, i, k_tab[i]);
            end else passed++;
            wait_cycle();
        end
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || SubKeyValid !== 1'b0) begin
            $display("FAIL %s_done: done=%b busy=%b valid=%b, want 1 0 0", tag, Done, Busy, SubKeyValid);
        end else passed++;
        wait_cycle();
        checks++;
        if (Done !== 1'b0) begin
            $display("FAIL %s_done_pulse: done=%b, want 0", tag, Done);
        end else passed++;
    endtask

    task automatic test_decrypt();
        int idx;
        Key = KEY_A; Decrypt = 1'b1; Start = 1'b1; SubKeyReady = 1'b1;
        wait_cycle();
        Start = 1'b0; Decrypt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = DEC_EN ? 15 - i : i;
            checks++;
            if (SubKeyValid !== 1'b1 || Round !== i[3:0] || SubKey !== k_tab[idx]) begin
                $display("FAIL dec_k%0d: valid=%b round=%0d subkey=%h, want 1 %0d %h",
                         i, SubKeyValid, Round, SubKey, i, k_tab[idx]);
            end else passed++;
            wait_cycle();
        end
        checks++;
        if (Done !== 1'b1 || SubKeyValid !== 1'b0) begin
            $display("FAIL dec_done: done=%b valid=%b, want 1 0", Done, SubKeyValid);
        end else passed++;
        wait_cycle();
    endtask

    task automatic test_stall();
        int idx = 0;
        int cyc = 0;
        Key = KEY_A; Decrypt = 1'b0; Start = 1'b1; SubKeyReady = 1'b0;
        wait_cycle();
        Start = 1'b0;
        while (idx < 16 && cyc < 200) begin
            SubKeyReady = 1'($urandom_range(0, 1));
            checks++;
            if (SubKeyValid !== 1'b1 || Done !== 1'b0 || Round !== idx[3:0] || SubKey !== k_tab[idx]) begin
                $display("FAIL stall_c%0d: valid=%b done=%b round=%0d subkey=%h, want 1 0 %0d %h",
                         cyc, SubKeyValid, Done, Round, SubKey, idx, k_tab[idx]);
            end else passed++;
            wait_cycle();
            if (SubKeyReady) idx++;
            cyc++;
        end
        checks++;
        if (idx != 16 || Done !== 1'b1) begin
            $display("FAIL stall_done: handshakes=%0d done=%b, want 16 1", idx, Done);
        end else passed++;
        SubKeyReady = 1'b1;
        wait_cycle();
    endtask

    task automatic test_start_ignored();
        Key = KEY_A; Decrypt = 1'b0; Start = 1'b1; SubKeyReady = 1'b1;
        wait_cycle();
        Start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (SubKeyValid !== 1'b1 || Round !== i[3:0] || SubKey !== k_tab[i]) begin
                $display("FAIL ign_k%0d: valid=%b round=%0d subkey=%h, want 1 %0d %h",
                         i, SubKeyValid, Round, SubKey, i, k_tab[i]);
            end else passed++;
            if (i == 5 || i == 15) begin
                Start = 1'b1; Key = KEY_ONE;
            end
            wait_cycle();
            Start = 1'b0;
        end
        checks++;
        if (Done !== 1'b1 || SubKeyValid !== 1'b0 || Busy !== 1'b0) begin
            $display("FAIL ign_done: done=%b valid=%b busy=%b, want 1 0 0", Done, SubKeyValid, Busy);
        end else passed++;
        wait_cycle();
        checks++;
        if (SubKeyValid !== 1'b0 || Busy !== 1'b0) begin
            $display("FAIL ign_idle: valid=%b busy=%b, want 0 0", SubKeyValid, Busy);
        end else passed++;
    endtask

    task automatic test_reset_mid_run();
        int cyc = 0;
        Key = KEY_A; Decrypt = 1'b0; Start = 1'b1; SubKeyReady = 1'b1;
        wait_cycle();
        Start = 1'b0;
        repeat (7) wait_cycle();
        checks++;
        if (Round !== 4'd7 || SubKey !== k_tab[7]) begin
            $display("FAIL rst_pre: round=%0d subkey=%h, want 7 %h", Round, SubKey, k_tab[7]);
        end else passed++;
        Reset = 1'b1;
        wait_cycle();
        Reset = 1'b0;
        checks++;
        if (SubKeyValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Round !== 4'd0 || SubKey !== 48'h0) begin
            $display("FAIL rst_mid: valid=%b busy=%b done=%b round=%0d subkey=%h, want 0 0 0 0 0",
                     SubKeyValid, Busy, Done, Round, SubKey);
        end else passed++;
        Key = KEY_ONE; Start = 1'b1;
        wait_cycle();
        Start = 1'b0;
        checks++;
        if (SubKeyValid !== 1'b1 || Round !== 4'd0 || SubKey !== 48'hFFFFFFFFFFFF) begin
            $display("FAIL rst_restart: valid=%b round=%0d subkey=%h, want 1 0 ffffffffffff",
                     SubKeyValid, Round, SubKey);
        end else passed++;
        while (Done !== 1'b1 && cyc < 20) begin
            wait_cycle();
            cyc++;
        end
        checks++;
        if (Done !== 1'b1 || cyc != 16) begin
            $display("FAIL rst_drain: done=%b cycles=%0d, want 1 16", Done, cyc);
        end else passed++;
        wait_cycle();
    endtask

    initial begin
        test_reset();
        test_encrypt(KEY_A, "enc");
        test_decrypt();
        test_stall();
        test_start_ignored();
        test_reset_mid_run();
        test_encrypt(KEY_A ^ 64'h0101010101010101, "parity");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_des_key_schedule
`default_nettype wire
